// File: rtl/ps2_kb_hexview_pkg.sv
// Shared definitions for the PS/2 keyboard hex viewer: prefix bytes, receiver states, 7-seg table.
// Pure declarations, so no latency and no flow control.
package ps2_kb_hexview_pkg;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ps2_kb_hexview_rx_frame.sv
// PS/2 frame receiver: sync, glitch filter, fall detect, 11-bit frame FSM with stall timeout.
// Strobes appear FILT_LEN+3 cycles after the raw stop-bit fall; no backpressure (device-paced).
module ps2_rx_frame
    import ps2_kb_hexview_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d_i,
    input  logic       ps2c_i,
    output logic [7:0] byte_o,
    output logic       byte_ok_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILT_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    c_sync_q, d_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;
    rx_state_e     state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic          d_bit;

    assign d_bit = d_sync_q[1];

    // The filtered clock only follows the synced one after FILT_LEN disagreeing samples in a row.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall_d = 1'b0;
        if (c_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = c_sync_q[1];
                fall_d = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        tcnt_d  = '0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        if (fall_q) begin
            case (state_q)
                RX_IDLE: begin
                    if (!d_bit) begin
                        state_d = RX_DATA;
                        bcnt_d  = 3'd0;
                    end
                end
                RX_DATA: begin
                    sr_d   = {d_bit, sr_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = d_bit;
                    state_d = RX_STOP;
                end
                default: begin
                    if (((^sr_q) ^ par_q) && d_bit) ok_d = 1'b1;
                    else                            err_d = 1'b1;
                    state_d = RX_IDLE;
                end
            endcase
        end else if (state_q != RX_IDLE) begin
            if (tcnt_q == TW'(TIMEOUT_CYC - 1)) state_d = RX_IDLE;
            else                                tcnt_d  = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            fall_q   <= 1'b0;
            state_q  <= RX_IDLE;
            sr_q     <= 8'h00;
            bcnt_q   <= 3'd0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c_i};
            d_sync_q <= {d_sync_q[0], ps2d_i};
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            fall_q   <= fall_d;
            state_q  <= state_d;
            sr_q     <= sr_d;
            bcnt_q   <= bcnt_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    assign byte_o      = sr_q;
    assign byte_ok_o   = ok_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_kb_hexview.sv
// PS/2 keyboard front end: E0/F0 decode, make-code history on a multiplexed 7-seg, key LED.
// key_valid follows the raw stop-bit fall by FILT_LEN+4 cycles; no backpressure (device-paced).
module ps2_kb_hexview
    import ps2_kb_hexview_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int REFRESH_DIV = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ps2d,
    input  logic            ps2c,
    output logic [7:0]      seg,
    output logic [NDIG-1:0] an,
    output logic            key_valid,
    output logic [7:0]      key_code,
    output logic            key_ext,
    output logic            key_break,
    output logic            led,
    output logic            err
);

    localparam int HW = 4 * NDIG;
    localparam int IW = (NDIG > 2) ? $clog2(NDIG) : 1;
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [7:0]      rx_byte;
    logic            rx_ok, rx_err;

    logic            ext_f_q, ext_f_d, brk_f_q, brk_f_d;
    logic            kv_q, kv_d, kext_q, kext_d, kbrk_q, kbrk_d;
    logic [7:0]      kcode_q, kcode_d;
    logic [HW-1:0]   hist_q, hist_d;
    logic            new_ext_q, new_ext_d;
    logic            led_q, led_d;
    logic [8:0]      led_key_q, led_key_d;
    logic            err_q, err_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      nib;

    ps2_rx_frame #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .ps2d_i      (ps2d),
        .ps2c_i      (ps2c),
        .byte_o      (rx_byte),
        .byte_ok_o   (rx_ok),
        .frame_err_o (rx_err)
    );

    always_comb begin
        ext_f_d = ext_f_q;
        brk_f_d = brk_f_q;
        kv_d    = 1'b0;
        kcode_d = kcode_q;
        kext_d  = kext_q;
        kbrk_d  = kbrk_q;
        if (rx_ok) begin
            if (rx_byte == PFX_EXT) begin
                ext_f_d = 1'b1;
            end else if (rx_byte == PFX_BRK) begin
                brk_f_d = 1'b1;
            end else begin
                kv_d    = 1'b1;
                kcode_d = rx_byte;
                kext_d  = ext_f_q;
                kbrk_d  = brk_f_q;
                ext_f_d = 1'b0;
                brk_f_d = 1'b0;
            end
        end
    end

    // History and LED follow the registered event, one cycle behind key_valid.
    always_comb begin
        hist_d    = hist_q;
        new_ext_d = new_ext_q;
        led_d     = led_q;
        led_key_d = led_key_q;
        err_d     = err_q | rx_err;
        if (kv_q) begin
            if (!kbrk_q) begin
                hist_d    = HW'({hist_q, kcode_q});
                new_ext_d = kext_q;
                led_d     = 1'b1;
                led_key_d = {kext_q, kcode_q};
            end else if (led_key_q == {kext_q, kcode_q}) begin
                led_d     = 1'b0;
            end
        end
    end

    always_comb begin
        rcnt_d = rcnt_q + 1'b1;
        idx_d  = idx_q;
        if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            idx_d  = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
        nib = hist_q[3:0];
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) nib = hist_q[4*i +: 4];
        end
        an_d  = ~(NDIG'(1) << idx_q);
        seg_d = {~((idx_q == '0) && new_ext_q), hex7seg(nib)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_f_q   <= 1'b0;
            brk_f_q   <= 1'b0;
            kv_q      <= 1'b0;
            kcode_q   <= 8'h00;
            kext_q    <= 1'b0;
            kbrk_q    <= 1'b0;
            hist_q    <= '0;
            new_ext_q <= 1'b0;
            led_q     <= 1'b0;
            led_key_q <= 9'h000;
            err_q     <= 1'b0;
            rcnt_q    <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= 8'hFF;
        end else begin
            ext_f_q   <= ext_f_d;
            brk_f_q   <= brk_f_d;
            kv_q      <= kv_d;
            kcode_q   <= kcode_d;
            kext_q    <= kext_d;
            kbrk_q    <= kbrk_d;
            hist_q    <= hist_d;
            new_ext_q <= new_ext_d;
            led_q     <= led_d;
            led_key_q <= led_key_d;
            err_q     <= err_d;
            rcnt_q    <= rcnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign key_valid = kv_q;
    assign key_code  = kcode_q;
    assign key_ext   = kext_q;
    assign key_break = kbrk_q;
    assign led       = led_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ps2_kb_hexview.sv
// Directed bench for ps2_kb_hexview: frames, prefixes, parity error, stall timeout, mid-frame reset.
module tb_ps2_kb_hexview;

    localparam int NDIG     = 4;
    localparam int FILT_LEN = 8;
    localparam int TMO      = 2000;
    localparam int REF      = 16;

    // Active-low {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SEG7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ps2d = 1'b1;
    logic            ps2c = 1'b1;
    logic [7:0]      seg;
    logic [NDIG-1:0] an;
    logic            key_valid;
    logic [7:0]      key_code;
    logic            key_ext;
    logic            key_break;
    logic            led;
    logic            err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ev_cnt = 0;
    int kv_cyc = 0;
    int fall_cyc = 0;

    ps2_kb_hexview #(
        .NDIG        (NDIG),
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TMO),
        .REFRESH_DIV (REF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2d      (ps2d),
        .ps2c      (ps2c),
        .seg       (seg),
        .an        (an),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .led       (led),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            ev_cnt++;
            kv_cyc = cyc;
        end
    end

    // Digit scan monitor: every change of an must be a one-hot-low step to the next digit,
    // and every complete digit period must last REF cycles.
    logic [NDIG-1:0] prev_an = '1;
    int              run_len = 0;
    bit              run_ok  = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            run_ok  = 1'b0;
            run_len = 0;
            prev_an = an;
        end else if (an !== prev_an) begin
            chk("an_onehot", 32'($countones(~an)), 32'd1);
            if (prev_an !== '1) begin
                chk("an_step", 32'(an), 32'({prev_an[NDIG-2:0], prev_an[NDIG-1]}));
                if (run_ok) chk("an_hold", 32'(run_len), 32'(REF));
            end
            run_ok  = 1'b1;
            run_len = 1;
            prev_an = an;
        end else begin
            run_len++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // nbits < 8 stops after the start bit plus that many data bits.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        int          nb;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        nb   = (nbits >= 8) ? 11 : nbits + 1;
        for (int i = 0; i < nb; i++) begin
            ps2d = bits[i];
            tick(100);
            ps2c     = 1'b0;
            fall_cyc = cyc;
            tick(200);
            ps2c = 1'b1;
            tick(100);
        end
        ps2d = 1'b1;
    endtask

    task automatic check_display(input string tag, input logic [15:0] hx, input bit dp);
        logic [7:0] segs [NDIG];
        logic [3:0] n;
        int         k;
        for (int i = 0; i < NDIG; i++) segs[i] = 8'h00;
        k = 0;
        @(negedge clk);
        while (an !== 4'hE && k < 4 * NDIG * REF) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_sync"}, 32'(an), 32'hE);
        for (int c = 0; c < NDIG * REF; c++) begin
            for (int i = 0; i < NDIG; i++) begin
                if (an === ~(4'b0001 << i)) segs[i] = seg;
            end
            @(negedge clk);
        end
        for (int i = 0; i < NDIG; i++) begin
            n = hx[4*i +: 4];
            chk($sformatf("%s_d%0d", tag, i), 32'(segs[i]), 32'({~(dp && i == 0), SEG7[n]}));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg"},  32'(seg), 32'hFF);
        chk({tag, "_an"},   32'(an), 32'hF);
        chk({tag, "_kv"},   32'(key_valid), 32'd0);
        chk({tag, "_code"}, 32'(key_code), 32'd0);
        chk({tag, "_ext"},  32'(key_ext), 32'd0);
        chk({tag, "_brk"},  32'(key_break), 32'd0);
        chk({tag, "_led"},  32'(led), 32'd0);
        chk({tag, "_err"},  32'(err), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int k;
        tick(5);
        @(negedge clk);
        check_reset_outputs("rst0");
        tick(1);
        reset = 1'b0;
        tick(20);

        // 1: plain make
        e0 = ev_cnt;
        send_frame(8'h1C, 1'b0, 8);
        chk("t1_ev", 32'(ev_cnt - e0), 32'd1);
        chk("t1_code", 32'(key_code), 32'h1C);
        chk("t1_ext", 32'(key_ext), 32'd0);
        chk("t1_brk", 32'(key_break), 32'd0);
        chk("t1_led", 32'(led), 32'd1);
        chk("t1_lat", 32'(kv_cyc - fall_cyc), 32'(FILT_LEN + 4));
        check_display("t1_disp", 16'h001C, 1'b0);

        // 2: break
        e0 = ev_cnt;
        send_frame(8'hF0, 1'b0, 8);
        send_frame(8'h1C, 1'b0, 8);
        chk("t2_ev", 32'(ev_cnt - e0), 32'd1);
        chk("t2_code", 32'(key_code), 32'h1C);
        chk("t2_brk", 32'(key_break), 32'd1);
        chk("t2_led", 32'(led), 32'd0);
        check_display("t2_disp", 16'h001C, 1'b0);

        // 3: scrolling and extended key
        e0 = ev_cnt;
        send_frame(8'h1C, 1'b0, 8);
        send_frame(8'h32, 1'b0, 8);
        chk("t3_ev", 32'(ev_cnt - e0), 32'd2);
        check_display("t3a_disp", 16'h1C32, 1'b0);
        e0 = ev_cnt;
        send_frame(8'hE0, 1'b0, 8);
        send_frame(8'h75, 1'b0, 8);
        chk("t3b_ev", 32'(ev_cnt - e0), 32'd1);
        chk("t3b_code", 32'(key_code), 32'h75);
        chk("t3b_ext", 32'(key_ext), 32'd1);
        chk("t3b_brk", 32'(key_break), 32'd0);
        chk("t3b_led", 32'(led), 32'd1);
        check_display("t3b_disp", 16'h3275, 1'b1);

        // 5: stalled frame times out silently
        e0 = ev_cnt;
        send_frame(8'h32, 1'b0, 5);
        tick(3000);
        chk("t5_ev", 32'(ev_cnt - e0), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        send_frame(8'h1C, 1'b0, 8);
        chk("t5_ev2", 32'(ev_cnt - e0), 32'd1);
        chk("t5_code", 32'(key_code), 32'h1C);
        chk("t5_ext", 32'(key_ext), 32'd0);
        check_display("t5_disp", 16'h751C, 1'b0);

        // 4: parity error is sticky, next good frame still accepted
        e0 = ev_cnt;
        send_frame(8'h1C, 1'b1, 8);
        chk("t4_ev", 32'(ev_cnt - e0), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        send_frame(8'h32, 1'b0, 8);
        chk("t4_ev2", 32'(ev_cnt - e0), 32'd1);
        chk("t4_code", 32'(key_code), 32'h32);
        chk("t4_err2", 32'(err), 32'd1);
        check_display("t4_disp", 16'h1C32, 1'b0);

        // 6: reset mid-frame
        send_frame(8'h75, 1'b0, 6);
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        check_reset_outputs("t6_rst");
        tick(3);
        reset = 1'b0;
        k = 0;
        @(negedge clk);
        while (an === 4'hF && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t6_an_first", 32'(an), 32'hE);
        e0 = ev_cnt;
        send_frame(8'h32, 1'b0, 8);
        chk("t6_ev", 32'(ev_cnt - e0), 32'd1);
        chk("t6_code", 32'(key_code), 32'h32);
        chk("t6_ext", 32'(key_ext), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_led", 32'(led), 32'd1);
        check_display("t6_disp", 16'h0032, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
